// File: rtl/pll_loop_filter.sv
// ---------------------------------------------------------------------------
// pll_loop_filter
//
// Proportional-integral loop filter for the all-digital PLL. Converts signed
// phase-error samples into the unsigned DCO tuning word, sequences DCO
// startup (OFF -> SETTLE -> TRACK) and reports lock.
//
// Ports:
//   CLK         system clock
//   nRST        asynchronous active-low reset
//   start       level, 1 = run the loop, 0 = stop and return to initial state
//   freeze      level, 1 = ignore error samples and hold integrator/lock state
//   err_valid   one-cycle strobe qualifying err
//   err         signed phase error (ERRLEN bits)
//   d_out       DCO tuning word (BITLEN bits)
//   d_valid     one-cycle pulse, d_out was just updated
//   dco_enable  DCO enable
//   locked      lock indicator
//
// Datapath: stage 1 updates the integrator I (BITLEN+FRAC bits, unsigned,
// saturating); stage 2 adds the proportional term of the same sample to the
// integer part of the freshly updated I and clamps into the tuning word.
// ---------------------------------------------------------------------------
module pll_loop_filter #(
  parameter int BITLEN        = 16,
  parameter int ERRLEN        = 8,
  parameter int FRAC          = 8,
  parameter int KP_SHIFT      = 2,
  parameter int KI_SHIFT      = 6,
  parameter logic [BITLEN-1:0] INIT_CODE = {1'b1, {(BITLEN-1){1'b0}}},
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 64
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     start,
  input  logic                     freeze,
  input  logic                     err_valid,
  input  logic signed [ERRLEN-1:0] err,
  output logic [BITLEN-1:0]        d_out,
  output logic                     d_valid,
  output logic                     dco_enable,
  output logic                     locked
);

  localparam int IW     = BITLEN + FRAC;     // integrator width
  localparam int SW     = IW + 2;            // signed integrator sum width
  localparam int DW     = BITLEN + 2;        // signed output sum width
  localparam int EW1    = ERRLEN + 1;        // magnitude width (holds |min|)
  localparam int CW     = $clog2(LOCK_COUNT + 1);
  localparam int SCW    = $clog2(SETTLE_CYCLES + 1);
  localparam int KI_LSH = FRAC - KI_SHIFT;

  localparam logic [IW-1:0]  INIT_INTEG = {INIT_CODE, {FRAC{1'b0}}};
  localparam logic [CW-1:0]  LOCK_MAX   = CW'(LOCK_COUNT);
  localparam logic [EW1-1:0] THRESH     = EW1'(LOCK_THRESH);
  localparam logic [SCW-1:0] SETTLE_LD  = SCW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SETTLE,
    ST_TRACK
  } state_t;

  state_t                   state_reg, state_next;
  logic [SCW-1:0]           settle_reg, settle_next;
  logic [IW-1:0]            integ_reg;
  logic signed [ERRLEN-1:0] err_q_reg;
  logic                     v1_reg;
  logic [CW-1:0]            lock_cnt_reg;

  logic                     accept;
  logic signed [SW-1:0]     err_ext;
  logic signed [SW-1:0]     integ_sum;
  logic [IW-1:0]            integ_sat;
  logic signed [DW-1:0]     prop_ext;
  logic signed [DW-1:0]     d_sum;
  logic [BITLEN-1:0]        d_sat;
  logic signed [EW1-1:0]    err_wide;
  logic [EW1-1:0]           err_mag;
  logic                     in_band;
  logic [CW-1:0]            lock_cnt_inc;

  // ---------------------------------------------------------------------
  // Startup sequencer: next-state logic. Dropping start overrides everything.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    case (state_reg)
      ST_OFF: begin
        if (start) begin
          state_next  = ST_SETTLE;
          settle_next = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        // Counter reaches zero on the same edge that enters TRACK, so the
        // DCO runs exactly SETTLE_CYCLES cycles before tracking.
        settle_next = settle_reg - 1'b1;
        if (settle_reg <= SCW'(1)) begin
          state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        state_next = ST_TRACK;
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase
    if (!start) begin
      state_next  = ST_OFF;
      settle_next = '0;
    end
  end

  // A sample is taken only while tracking, running and not frozen.
  assign accept = (state_reg == ST_TRACK) && start && !freeze && err_valid;

  // ---------------------------------------------------------------------
  // Stage-1 integrator sum, saturated to [0, 2^IW-1]. Two guard bits keep
  // both underflow (sign bit) and overflow (bit SW-2) visible.
  // ---------------------------------------------------------------------
  always_comb begin
    err_ext   = $signed({{(SW-ERRLEN){err[ERRLEN-1]}}, err}) <<< KI_LSH;
    integ_sum = $signed({2'b00, integ_reg}) + err_ext;
    if (integ_sum[SW-1]) begin
      integ_sat = '0;
    end else if (integ_sum[SW-2]) begin
      integ_sat = '1;
    end else begin
      integ_sat = integ_sum[IW-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Stage-2 output: integer part of the updated integrator plus the
  // proportional term of the registered sample, clamped to the code range.
  // ---------------------------------------------------------------------
  always_comb begin
    prop_ext = $signed({{(DW-ERRLEN){err_q_reg[ERRLEN-1]}}, err_q_reg}) <<< KP_SHIFT;
    d_sum    = $signed({2'b00, integ_reg[IW-1:FRAC]}) + prop_ext;
    if (d_sum[DW-1]) begin
      d_sat = '0;
    end else if (d_sum[DW-2]) begin
      d_sat = '1;
    end else begin
      d_sat = d_sum[BITLEN-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Lock detector inputs. The magnitude is taken one bit wider so the most
  // negative error keeps its true size instead of wrapping.
  // ---------------------------------------------------------------------
  always_comb begin
    err_wide     = $signed({err[ERRLEN-1], err});
    err_mag      = err_wide[EW1-1] ? EW1'(-err_wide) : EW1'(err_wide);
    in_band      = (err_mag <= THRESH);
    lock_cnt_inc = (lock_cnt_reg == LOCK_MAX) ? lock_cnt_reg : lock_cnt_reg + 1'b1;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= ST_OFF;
      settle_reg   <= '0;
      dco_enable   <= 1'b0;
      integ_reg    <= INIT_INTEG;
      err_q_reg    <= '0;
      v1_reg       <= 1'b0;
      d_out        <= INIT_CODE;
      d_valid      <= 1'b0;
      lock_cnt_reg <= '0;
      locked       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      dco_enable <= (state_next != ST_OFF);
      if (!start) begin
        // Stop discards any pending stage-2 result and any new sample.
        integ_reg    <= INIT_INTEG;
        v1_reg       <= 1'b0;
        d_out        <= INIT_CODE;
        d_valid      <= 1'b0;
        lock_cnt_reg <= '0;
        locked       <= 1'b0;
      end else begin
        v1_reg  <= accept;
        d_valid <= v1_reg;
        if (v1_reg) begin
          d_out <= d_sat;
        end
        if (accept) begin
          err_q_reg <= err;
          integ_reg <= integ_sat;
          if (in_band) begin
            lock_cnt_reg <= lock_cnt_inc;
            locked       <= (lock_cnt_inc == LOCK_MAX);
          end else begin
            lock_cnt_reg <= '0;
            locked       <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_loop_filter.sv
// ---------------------------------------------------------------------------
// tb_pll_loop_filter
//
// Directed bench for pll_loop_filter with default parameters. A table of
// single samples with hand-computed integrator/tuning-word values, plus
// hand-written sequences for startup, back-to-back gain accumulation, lock,
// freeze, stop, saturation and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pll_loop_filter;

  localparam longint I_MAX = 64'hFF_FFFF;
  localparam longint D_MAX = 64'hFFFF;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              start = 1'b0;
  logic              freeze = 1'b0;
  logic              err_valid = 1'b0;
  logic signed [7:0] err = '0;
  logic [15:0]       d_out;
  logic              d_valid;
  logic              dco_enable;
  logic              locked;

  int total = 0;
  int bad   = 0;

  // Small reference model of the loop (default gains: x4 on both paths).
  longint m_I;
  longint m_d;
  int     m_cnt;
  logic   m_lock;
  logic   pend;
  longint pend_d;

  typedef struct {
    int          e;
    logic [23:0] exp_i;
    logic [15:0] exp_d;
  } vec_t;
  vec_t vecs[6];

  pll_loop_filter dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .start      (start),
    .freeze     (freeze),
    .err_valid  (err_valid),
    .err        (err),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .dco_enable (dco_enable),
    .locked     (locked)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_I    = 64'h80_0000;
    m_d    = 64'h8000;
    m_cnt  = 0;
    m_lock = 1'b0;
    pend   = 1'b0;
    pend_d = 0;
  endtask

  task automatic model_sample(input int e);
    int mag;
    m_I = m_I + longint'(e) * 4;
    if (m_I < 0) m_I = 0;
    if (m_I > I_MAX) m_I = I_MAX;
    m_d = (m_I / 256) + longint'(e) * 4;
    if (m_d < 0) m_d = 0;
    if (m_d > D_MAX) m_d = D_MAX;
    mag = (e < 0) ? -e : e;
    if (mag <= 2) begin
      if (m_cnt < 64) m_cnt++;
      m_lock = (m_cnt == 64);
    end else begin
      m_cnt  = 0;
      m_lock = 1'b0;
    end
  endtask

  // Stop, start again and wait out the settle period; returns in TRACK.
  task automatic restart();
    start     = 1'b0;
    err_valid = 1'b0;
    freeze    = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    check("restart_dco_enable", 32'(dco_enable), 32'd1);
    repeat (16) cyc();
    model_reset();
  endtask

  // One accepted sample per call; consecutive calls are back-to-back.
  task automatic drive_sample(input int e);
    err_valid = 1'b1;
    err       = 8'(e);
    cyc();
    if (pend) begin
      check("b2b_d_valid", 32'(d_valid), 32'd1);
      check("b2b_d_out", 32'(d_out), 32'(pend_d));
    end
    model_sample(e);
    check("integ", 32'(dut.integ_reg), 32'(m_I));
    check("locked", 32'(locked), 32'(m_lock));
    pend   = 1'b1;
    pend_d = m_d;
  endtask

  // Idle cycle that lets a pending stage-2 result appear.
  task automatic drain();
    err_valid = 1'b0;
    cyc();
    check("drain_d_valid", 32'(d_valid), 32'(pend));
    if (pend) check("drain_d_out", 32'(d_out), 32'(pend_d));
    pend = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{4,    24'h800010, 16'h8010};
    vecs[1] = '{0,    24'h800010, 16'h8000};
    vecs[2] = '{-3,   24'h800004, 16'h7FF4};
    vecs[3] = '{-128, 24'h7FFE04, 16'h7DFE};
    vecs[4] = '{127,  24'h800000, 16'h81FC};
    vecs[5] = '{1,    24'h800004, 16'h8004};
    model_reset();

    // ---------------- startup ----------------
    repeat (2) cyc();
    check("rst_d_out", 32'(d_out), 32'h8000);
    check("rst_dco_enable", 32'(dco_enable), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_integ", 32'(dut.integ_reg), 32'h800000);
    nRST = 1'b1;
    cyc();
    check("off_dco_enable", 32'(dco_enable), 32'd0);
    start = 1'b1;
    cyc();
    check("start_dco_enable", 32'(dco_enable), 32'd1);
    err_valid = 1'b1;
    err       = 8'sd4;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("settle_d_valid", 32'(d_valid), 32'd0);
    end
    check("settle_integ", 32'(dut.integ_reg), 32'h800000);
    cyc();
    check("first_track_d_valid", 32'(d_valid), 32'd0);
    check("first_track_integ", 32'(dut.integ_reg), 32'h800010);
    err_valid = 1'b0;
    cyc();
    check("first_track_out_valid", 32'(d_valid), 32'd1);
    check("first_track_d_out", 32'(d_out), 32'h8010);
    cyc();
    check("d_valid_pulse_end", 32'(d_valid), 32'd0);
    $display("startup sequence done");

    // ---------------- table of single samples ----------------
    restart();
    for (int i = 0; i < 6; i++) begin
      err_valid = 1'b1;
      err       = 8'(vecs[i].e);
      cyc();
      check("vec_integ", 32'(dut.integ_reg), 32'(vecs[i].exp_i));
      err_valid = 1'b0;
      cyc();
      check("vec_d_valid", 32'(d_valid), 32'd1);
      check("vec_d_out", 32'(d_out), 32'(vecs[i].exp_d));
      $display("vec %0d err=%0d d_out=0x%h integ=0x%h", i, vecs[i].e, d_out, dut.integ_reg);
    end

    // ---------------- 16 samples of +4 accumulate into the integer part ----
    restart();
    drive_sample(4);
    drain();
    check("p4_d_out", 32'(d_out), 32'h8010);
    drive_sample(0);
    drain();
    check("p0_d_out", 32'(d_out), 32'h8000);
    for (int i = 0; i < 15; i++) drive_sample(4);
    drive_sample(0);
    drain();
    check("acc16_integ", 32'(dut.integ_reg), 32'h800100);
    check("acc16_d_out", 32'(d_out), 32'h8001);
    $display("accumulate sequence d_out=0x%h", d_out);

    // ---------------- lock detector ----------------
    restart();
    for (int k = 1; k <= 64; k++) drive_sample((k % 5) - 2);
    check("lock_after_64", 32'(locked), 32'd1);
    drive_sample(3);
    check("unlock_err3", 32'(locked), 32'd0);
    for (int k = 1; k <= 63; k++) drive_sample(-2);
    check("lock_after_63", 32'(locked), 32'd0);
    drive_sample(2);
    check("relock_64th", 32'(locked), 32'd1);
    drive_sample(-128);
    check("unlock_most_neg", 32'(locked), 32'd0);
    for (int k = 1; k <= 64; k++) drive_sample(k & 1);
    check("relock_again", 32'(locked), 32'd1);
    drain();
    $display("lock sequence locked=%0d", locked);

    // ---------------- freeze ----------------
    drive_sample(1);
    freeze    = 1'b1;
    err_valid = 1'b1;
    err       = 8'sd50;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("frz_d_valid", 32'(d_valid), (i == 0) ? 32'd1 : 32'd0);
      check("frz_d_out", 32'(d_out), 32'(pend_d));
      check("frz_locked", 32'(locked), 32'd1);
      check("frz_integ", 32'(dut.integ_reg), 32'(m_I));
    end
    pend      = 1'b0;
    freeze    = 1'b0;
    err_valid = 1'b0;
    cyc();
    check("frz_end_d_valid", 32'(d_valid), 32'd0);
    check("frz_end_integ", 32'(dut.integ_reg), 32'(m_I));
    $display("freeze sequence done");

    // ---------------- stop mid-operation ----------------
    drive_sample(2);
    check("pre_stop_locked", 32'(locked), 32'd1);
    start     = 1'b0;
    err_valid = 1'b1;
    err       = 8'sd4;
    cyc();
    check("stop_d_valid", 32'(d_valid), 32'd0);
    check("stop_dco_enable", 32'(dco_enable), 32'd0);
    check("stop_d_out", 32'(d_out), 32'h8000);
    check("stop_locked", 32'(locked), 32'd0);
    check("stop_integ", 32'(dut.integ_reg), 32'h800000);
    err_valid = 1'b0;
    cyc();
    check("stop_d_valid2", 32'(d_valid), 32'd0);
    pend = 1'b0;
    $display("stop sequence done");

    // ---------------- saturation ----------------
    restart();
    n = 0;
    while (m_I != I_MAX && n < 20000) begin
      drive_sample(127);
      n++;
    end
    check("sat_reached", 32'(m_I == I_MAX), 32'd1);
    drain();
    check("sat_d_out", 32'(d_out), 32'hFFFF);
    check("sat_integ", 32'(dut.integ_reg), 32'hFFFFFF);
    drive_sample(-128);
    check("desat_integ", 32'(dut.integ_reg), 32'hFFFDFF);
    drain();
    check("desat_d_out", 32'(d_out), 32'hFDFD);
    $display("saturation sequence samples=%0d d_out=0x%h", n, d_out);

    // ---------------- asynchronous reset in TRACK ----------------
    restart();
    drive_sample(20);
    err_valid = 1'b0;
    cyc();
    check("pre_rst_d_valid", 32'(d_valid), 32'd1);
    check("pre_rst_d_out", 32'(d_out), 32'h8050);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_d_out", 32'(d_out), 32'h8000);
    check("arst_d_valid", 32'(d_valid), 32'd0);
    check("arst_dco_enable", 32'(dco_enable), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_integ", 32'(dut.integ_reg), 32'h800000);
    #3;
    nRST = 1'b1;
    cyc();
    $display("async reset sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
